// File: rtl/outport_ctrl.sv
// Output-port controller: round-robin packet arbitration over the inports,
// credit-based flow control toward the next router and a registered link stage.
module outport_ctrl #(
  parameter int PORTS   = 5,
  parameter int FLIT_W  = 32,
  parameter int CREDITS = 4,
  parameter int PKT_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS-1:0]        port_rqs,
  input  logic [PORTS*FLIT_W-1:0] in_data,
  input  logic                    crt_in,
  output logic [PORTS-1:0]        arb_ack,
  output logic [FLIT_W-1:0]       output_channel,
  output logic                    diff_pair_p,
  output logic                    diff_pair_n,
  output logic                    credit_err
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CNT_W = $clog2(PKT_LEN + 1);
  localparam int CRD_W = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] PKT_CNT  = CNT_W'(PKT_LEN);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(CREDITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PORTS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   winner_r, winner_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0]   flit_cnt_r, flit_cnt_s;
  logic [CRD_W-1:0]   credits_r;
  logic [PORTS-1:0]   ack_s;
  logic               issue_s;
  logic               found_s;
  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W-1:0]   cand_s;
  logic               valid_r;
  logic [IDX_W-1:0]   sel_r;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? IDX_W'(0) : idx + IDX_W'(1);
  endfunction

  // Round-robin search: first requester at or above rr_ptr, wrapping
  always_comb begin
    found_s = 1'b0;
    pick_s  = IDX_W'(0);
    cand_s  = rr_ptr_r;
    for (int i = 0; i < PORTS; i++) begin
      if (!found_s && port_rqs[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
      cand_s = next_idx(cand_s);
    end
  end

  // Next-state and ack decision; an ack is only ever issued against a nonzero registered credit count
  always_comb begin
    state_s    = state_r;
    winner_s   = winner_r;
    rr_ptr_s   = rr_ptr_r;
    flit_cnt_s = flit_cnt_r;
    issue_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s && (credits_r != CRD_W'(0))) begin
          issue_s    = 1'b1;
          winner_s   = pick_s;
          flit_cnt_s = CNT_W'(1);
          if (PKT_CNT == CNT_W'(1)) begin
            state_s  = IDLE;
            rr_ptr_s = next_idx(pick_s);
          end else begin
            state_s  = SEND;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if ((flit_cnt_r < PKT_CNT) && (credits_r != CRD_W'(0))) begin
          issue_s    = 1'b1;
          flit_cnt_s = flit_cnt_r + CNT_W'(1);
          if (flit_cnt_r == LAST_CNT) begin
            state_s  = IDLE;
            rr_ptr_s = next_idx(winner_r);
          end else begin
            state_s  = SEND;
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // One-hot ack toward the latched winner
  always_comb begin
    ack_s = '0;
    if (issue_s) begin
      ack_s[winner_s] = 1'b1;
    end else begin
      ack_s = '0;
    end
  end

  // Arbitration state, packet counter and registered ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      winner_r   <= IDX_W'(0);
      rr_ptr_r   <= IDX_W'(0);
      flit_cnt_r <= CNT_W'(0);
      arb_ack    <= '0;
    end else begin
      state_r    <= state_s;
      winner_r   <= winner_s;
      rr_ptr_r   <= rr_ptr_s;
      flit_cnt_r <= flit_cnt_s;
      arb_ack    <= ack_s;
    end
  end

  // Downstream credit count; a return at full count is flagged and otherwise ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_r  <= CRD_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({crt_in, issue_s})
        2'b10: begin
          if (credits_r == CRD_MAX) begin
            credit_err <= 1'b1;
          end else begin
            credits_r <= credits_r + CRD_W'(1);
          end
        end
        2'b01:   credits_r <= credits_r - CRD_W'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  // Link stage: the select follows the ack by one cycle so it lines up with the popped flit on in_data
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r        <= 1'b0;
      sel_r          <= IDX_W'(0);
      output_channel <= '0;
      diff_pair_p    <= 1'b0;
      diff_pair_n    <= 1'b1;
    end else begin
      valid_r     <= |arb_ack;
      sel_r       <= winner_r;
      diff_pair_p <= valid_r;
      diff_pair_n <= ~valid_r;
      if (valid_r) begin
        output_channel <= in_data[int'(sel_r)*FLIT_W +: FLIT_W];
      end else begin
        output_channel <= output_channel;
      end
    end
  end

endmodule

// File: doc/outport_ctrl.md
Name: outport_ctrl

Overview:
- Output-port controller for one of the router's 5 directions; sits directly downstream of the inports.
- Arbitrates the inport request bits aimed at this output and returns arb_ack to the winner, which pops one flit from its FIFO per ack.
- Selects the winner's channel_data through an internal crossbar mux, registers the flit onto the link, and signals validity on the differential pair.
- Tracks downstream buffer credits returned by the next router's inport (its crt_out).

Parameters:
- PORTS, 5, number of inports competing for this output
- FLIT_W, 32, flit width in bits
- CREDITS, 4, downstream inport FIFO depth; initial and maximum credit count
- PKT_LEN, 4, flits per packet (header included); grant held for the whole packet

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- port_rqs  in  PORTS  bit i = inport i requests this output; held until its packet completes
- in_data  in  PORTS*FLIT_W  concatenated channel_data of all inports; slice i = bits [i*FLIT_W +: FLIT_W]
- crt_in  in  1  one-cycle credit return pulse from the downstream inport
- arb_ack  out  PORTS  one-hot per-flit acknowledge to inports; registered
- output_channel  out  FLIT_W  registered flit to the downstream input_channel
- diff_pair_p  out  1  link valid, true polarity
- diff_pair_n  out  1  always the complement of diff_pair_p
- credit_err  out  1  sticky; set when crt_in arrives while the credit count is already CREDITS

Behaviour:
- Reset values (synchronous, rst=1, takes priority over all other events):
  - arb_ack=0, output_channel=0, diff_pair_p=0, diff_pair_n=1, credit_err=0
  - credits=CREDITS, rr_ptr=0, flit_cnt=0, state=IDLE
  - internal valid pipeline cleared
- Reset mid-packet abandons the packet with no further ack or flit output.
- Credit counter (range 0..CREDITS):
  - Decrements in every cycle in which an ack is issued.
  - Increments on crt_in.
  - Both in the same cycle: count unchanged.
  - crt_in with no ack while at CREDITS: count stays at CREDITS and credit_err is set.
- State machine:
  - IDLE:
    - If port_rqs != 0 and credits > 0, pick the winner by round-robin: first set bit searching upward from rr_ptr, wrapping modulo PORTS.
    - Latch the winner, assert arb_ack[winner] in the next cycle, flit_cnt=1, go to SEND.
    - If there are no requests, or credits == 0, remain in IDLE with arb_ack=0.
  - SEND:
    - Each cycle, if flit_cnt < PKT_LEN and credits > 0, assert arb_ack[winner] and increment flit_cnt.
    - If credits == 0, drop arb_ack (stall) and hold flit_cnt.
    - The credit check uses the registered count, so an ack is never issued at 0.
    - When the ack for flit PKT_LEN is issued, go to IDLE next cycle and set rr_ptr = (winner+1) mod PORTS.
    - Requests from other ports are ignored until then.
    - A new arbitration can start in the first IDLE cycle.
- Latency:
  - Request first sampled at cycle t; arb_ack at t+1.
  - The inport FIFO presents the flit on in_data at t+2.
  - output_channel updates and diff_pair_p=1 at t+3.
  - diff_pair_p is high for exactly one cycle per acked flit, PKT_LEN pulses per packet.
  - Stall gaps on arb_ack propagate 2 cycles later as diff_pair_p=0.
  - output_channel holds its last value when not valid.
- The mux select is the winner index delayed to align with the ack-to-data latency. A new winner is never applied to in-flight flits of the previous packet.
- arb_ack is always one-hot or zero.

Test Plan:
- Reset → arb_ack=0, diff_pair_p=0, diff_pair_n=1, output_channel=0, credit_err=0; 4 flits may be sent before any crt_in.
- Single request, port_rqs=00100, in_data slice 2 = 0xA1000001..04, crt_in pulsed each cycle → arb_ack=00100 for 4 consecutive cycles from t+1; output_channel 0xA1000001..04 on t+3..t+6 with diff_pair_p=1.
- Contention, port_rqs=10011 held continuously → packets granted in order port 0, 1, 4, 0 with rr_ptr advancing; no ack overlap; at least 1 IDLE cycle between packets.
- Credit starvation, no crt_in → exactly 4 acks, then arb_ack=0 with state held; crt_in pulsed once → exactly one more ack.
- crt_in asserted in the same cycle as an ack → credit count unchanged. crt_in pulsed at full credits → credit_err=1 and stays set until rst.
- rst asserted after the 2nd ack of a packet → all outputs return to reset values the next cycle; no further diff_pair_p pulses; next arbitration starts from port 0.
